axi_lite_adder_master: RTL

- AXI4-Lite initiator that drives the adder peripheral's slave register interface from fabric logic.
- Accepts an operand pair on a valid/ready command port.
- Writes operand A and operand B to the peripheral's operand registers, then reads back the sum register.
- Returns the 8-bit result and an error flag on a valid/ready response port. It sits beside the adder system, on the master side of its slave interface.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_adder_master_if.sv | 36 +++
 rtl/axi_lite_wr_channel.sv | 67 ++++++
 rtl/axi_lite_adder_master.sv | 117 +++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite adder initiator: response codes,
// controller states and default register offsets of the adder slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_RD,
        ST_RSP
    } state_t;

    localparam int unsigned DEF_OFF_A   = 'h0;
    localparam int unsigned DEF_OFF_B   = 'h4;
    localparam int unsigned DEF_OFF_RES = 'h8;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_adder_master_if.sv
// AXI4-Lite bus between the adder initiator (master) and the adder peripheral (slave).
interface axi_lite_adder_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/axi_lite_wr_channel.sv
// One AXI4-Lite single-byte write: AW and W issued together, B accepted while busy.
// A start pulse on the same edge as done chains straight into the next write.
module axi_lite_wr_channel
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              done,
    output logic              err
);
    logic busy;
    logic b_seen;
    logic err_q;
    logic b_hs;

    assign wstrb  = 4'b0001;
    assign bready = busy;
    assign b_hs   = bvalid & busy;

    // Each leg counts as complete if it finished earlier or handshakes this cycle.
    assign done = busy & (~awvalid | awready) & (~wvalid | wready) & (b_seen | b_hs);
    assign err  = err_q | (b_hs & resp_err(bresp));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            b_seen  <= 1'b0;
            err_q   <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            b_seen  <= 1'b0;
            err_q   <= 1'b0;
            awaddr  <= addr;
            wdata   <= {24'h0, data};
        end else if (busy) begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
            if (b_hs) begin
                b_seen <= 1'b1;
                err_q  <= err;
            end
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_adder_master.sv
// AXI4-Lite initiator for the adder peripheral: writes operands A and B,
// reads back the result register, and returns result plus error flag.
module axi_lite_adder_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] OFF_A     = ADDR_W'(DEF_OFF_A),
    parameter logic [ADDR_W-1:0] OFF_B     = ADDR_W'(DEF_OFF_B),
    parameter logic [ADDR_W-1:0] OFF_RES   = ADDR_W'(DEF_OFF_RES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_error,
    axi_lite_adder_master_if.master m
);
    state_t            state, state_nx;
    logic [7:0]        op_b;
    logic              err_acc;
    logic              wr_start, wr_done, wr_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              r_hs;

    assign cmd_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RSP);
    assign m.m_rready  = (state == ST_RD);
    assign m.m_arvalid = arvalid;
    assign m.m_araddr  = araddr;
    assign r_hs        = m.m_rvalid & (state == ST_RD);

    axi_lite_wr_channel #(.ADDR_W(ADDR_W)) u_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wr_start),
        .addr    (wr_addr),
        .data    (wr_data),
        .awaddr  (m.m_awaddr),
        .awvalid (m.m_awvalid),
        .awready (m.m_awready),
        .wdata   (m.m_wdata),
        .wstrb   (m.m_wstrb),
        .wvalid  (m.m_wvalid),
        .wready  (m.m_wready),
        .bresp   (m.m_bresp),
        .bvalid  (m.m_bvalid),
        .bready  (m.m_bready),
        .done    (wr_done),
        .err     (wr_err)
    );

    // Operand A goes straight from the command port into the write channel;
    // the B write is launched on the same edge that completes the A write.
    always_comb begin
        state_nx = state;
        wr_start = 1'b0;
        wr_addr  = BASE_ADDR + OFF_A;
        wr_data  = cmd_a;
        unique case (state)
            ST_IDLE: if (cmd_valid) begin
                wr_start = 1'b1;
                state_nx = ST_WR_A;
            end
            ST_WR_A: begin
                wr_addr = BASE_ADDR + OFF_B;
                wr_data = op_b;
                if (wr_done) begin
                    wr_start = 1'b1;
                    state_nx = ST_WR_B;
                end
            end
            ST_WR_B: if (wr_done) state_nx = ST_RD;
            ST_RD:   if (r_hs) state_nx = ST_RSP;
            ST_RSP:  if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_b       <= '0;
            err_acc    <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && cmd_valid) begin
                op_b    <= cmd_b;
                err_acc <= 1'b0;
            end
            if (wr_done) err_acc <= err_acc | wr_err;
            if (state == ST_WR_B && wr_done) begin
                arvalid <= 1'b1;
                araddr  <= BASE_ADDR + OFF_RES;
            end else if (m.m_arready) begin
                arvalid <= 1'b0;
            end
            if (r_hs) begin
                rsp_result <= m.m_rdata[7:0];
                rsp_error  <= err_acc | resp_err(m.m_rresp);
            end
        end
    end

endmodule
